// File: rtl/sd_cmd_serial_host_p.sv
// SD card command-line host engine.
// Serialises a 40-bit command with CRC7 and end bit on the CMD line, optionally
// collects a short or long response, checks it, waits the post-transaction gap,
// and hands the result back over a 4-phase REQ/ACK handshake.
module sd_cmd_serial_host_p #(
   parameter int SHORT_LEN = 48,
   parameter int LONG_LEN  = 136,
   parameter int NCR_MAX   = 64,
   parameter int NCC_W     = 4
) (
   input  logic                SD_CLK_IN,
   input  logic                RST_IN,
   input  logic [15:0]         SETTING_IN,
   input  logic [39:0]         CMD_IN,
   input  logic                REQ_IN,
   input  logic                ACK_IN,
   input  logic                cmd_dat_i,
   output logic                cmd_out_o,
   output logic                cmd_oe_o,
   output logic                ACK_OUT,
   output logic [2:0]          STATUS,
   output logic [LONG_LEN-2:0] RSP_OUT
);

   // One shared counter serves every timed state, so it is sized for the longest.
   localparam int CNT_W = $clog2(LONG_LEN + NCR_MAX + 8 + (1 << NCC_W));

   localparam logic [CNT_W-1:0] CMD_BITS      = CNT_W'(40);
   localparam logic [CNT_W-1:0] CRC_DONE      = CNT_W'(47);
   localparam logic [CNT_W-1:0] SEND_END      = CNT_W'(48);
   localparam logic [CNT_W-1:0] NCR_LAST      = CNT_W'(NCR_MAX - 1);
   localparam logic [CNT_W-1:0] SHORT_LAST    = CNT_W'(SHORT_LEN - 2);
   localparam logic [CNT_W-1:0] LONG_LAST     = CNT_W'(LONG_LEN - 2);
   localparam logic [CNT_W-1:0] SHORT_CRC_END = CNT_W'(SHORT_LEN - 9);
   localparam logic [CNT_W-1:0] LONG_CRC_BEG  = CNT_W'(7);
   localparam logic [CNT_W-1:0] LONG_CRC_END  = CNT_W'(LONG_LEN - 9);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      NCR_WAIT,
      RECV,
      NCC_DLY,
      ACK,
      REQ_LOW
   } state_t;

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt;
   logic [39:0]          cmd_sh;
   logic [6:0]           crc;
   logic                 rsp_en_r;
   logic                 rsp_long_r;
   logic                 crc_chk_r;
   logic [NCC_W-1:0]     ncc_r;

   logic [CNT_W-1:0]     rx_last;
   logic [CNT_W-1:0]     dly_last;
   logic [LONG_LEN-2:0]  rsp_shift;
   logic                 crc_feed;
   logic                 unused_setting;

   // CRC7, polynomial x^7 + x^3 + 1, one bit per call, MSB first.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   assign unused_setting = ^SETTING_IN[15:3+NCC_W];
   assign ACK_OUT        = (state == ACK);

   // Derived terminal counts and the response shift/CRC window.
   always_comb begin
      rx_last   = rsp_long_r ? LONG_LAST : SHORT_LAST;
      dly_last  = CNT_W'(7) + CNT_W'(ncc_r);
      rsp_shift = {RSP_OUT[LONG_LEN-3:0], cmd_dat_i};
      // Short frames cover start bit + 39 bits; the start bit is 0 and the CRC
      // starts at 0, so feeding it is a no-op. Long frames skip the 8-bit header.
      crc_feed  = rsp_long_r ? ((cnt >= LONG_CRC_BEG) && (cnt < LONG_CRC_END))
                             : (cnt < SHORT_CRC_END);
   end

   // State register.
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (REQ_IN) state_nx = SEND;
         SEND:     if (cnt == SEND_END) state_nx = rsp_en_r ? NCR_WAIT : NCC_DLY;
         NCR_WAIT: begin
            if (!cmd_dat_i)           state_nx = RECV;
            else if (cnt == NCR_LAST) state_nx = NCC_DLY;
         end
         RECV:     if (cnt == rx_last) state_nx = NCC_DLY;
         NCC_DLY:  if (cnt == dly_last) state_nx = ACK;
         ACK:      if (ACK_IN) state_nx = REQ_LOW;
         REQ_LOW:  if (!REQ_IN) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Datapath: command serialiser, response deserialiser, counters and status.
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         cnt        <= '0;
         cmd_sh     <= '0;
         crc        <= '0;
         rsp_en_r   <= 1'b0;
         rsp_long_r <= 1'b0;
         crc_chk_r  <= 1'b0;
         ncc_r      <= '0;
         cmd_out_o  <= 1'b1;
         cmd_oe_o   <= 1'b0;
         STATUS     <= '0;
         RSP_OUT    <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_oe_o  <= 1'b0;
               cmd_out_o <= 1'b1;
               if (REQ_IN) begin
                  cmd_sh     <= CMD_IN;
                  rsp_en_r   <= SETTING_IN[0];
                  rsp_long_r <= SETTING_IN[1];
                  crc_chk_r  <= SETTING_IN[2];
                  ncc_r      <= SETTING_IN[3+NCC_W-1:3];
                  STATUS     <= '0;
                  RSP_OUT    <= '0;
                  cnt        <= '0;
                  crc        <= '0;
               end
            end
            SEND: begin
               if (cnt == SEND_END) begin
                  cmd_oe_o  <= 1'b0;
                  cmd_out_o <= 1'b1;
                  cnt       <= '0;
                  crc       <= '0;
               end else begin
                  cmd_oe_o <= 1'b1;
                  cnt      <= cnt + 1'b1;
                  if (cnt < CMD_BITS) begin
                     cmd_out_o <= cmd_sh[39];
                     cmd_sh    <= {cmd_sh[38:0], 1'b0};
                     crc       <= crc7_step(crc, cmd_sh[39]);
                  end else if (cnt < CRC_DONE) begin
                     cmd_out_o <= crc[6];
                     crc       <= {crc[5:0], 1'b0};
                  end else begin
                     cmd_out_o <= 1'b1;
                  end
               end
            end
            NCR_WAIT: begin
               if (!cmd_dat_i) begin
                  cnt <= '0;
                  crc <= crc7_step(crc, 1'b0);
               end else if (cnt == NCR_LAST) begin
                  STATUS[0] <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RECV: begin
               RSP_OUT <= rsp_shift;
               if (crc_feed) crc <= crc7_step(crc, cmd_dat_i);
               if (cnt == rx_last) begin
                  cnt       <= '0;
                  STATUS[2] <= ~cmd_dat_i;
                  if (crc_chk_r && (rsp_shift[7:1] != crc)) STATUS[1] <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            NCC_DLY: begin
               cmd_oe_o <= 1'b0;
               if (cnt == dly_last) cnt <= '0;
               else                 cnt <= cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_serial_host_p.sv
// Directed bench for sd_cmd_serial_host_p: command framing, response capture,
// CRC/end-bit/timeout status, handshake timing and asynchronous reset.
module tb_sd_cmd_serial_host_p;

   logic         clk;
   logic         rst;
   logic [15:0]  setting;
   logic [39:0]  cmd;
   logic         req;
   logic         ack_in;
   logic         cmd_dat_i;
   logic         cmd_out_o;
   logic         cmd_oe_o;
   logic         ack_out;
   logic [2:0]   status;
   logic [134:0] rsp_out;

   int errors = 0;
   int checks = 0;

   sd_cmd_serial_host_p dut (
      .SD_CLK_IN  (clk),
      .RST_IN     (rst),
      .SETTING_IN (setting),
      .CMD_IN     (cmd),
      .REQ_IN     (req),
      .ACK_IN     (ack_in),
      .cmd_dat_i  (cmd_dat_i),
      .cmd_out_o  (cmd_out_o),
      .cmd_oe_o   (cmd_oe_o),
      .ACK_OUT    (ack_out),
      .STATUS     (status),
      .RSP_OUT    (rsp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference CRC7 over the low n bits of v, MSB first.
   function automatic logic [6:0] ref_crc7(input logic [135:0] v, input int n);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = n - 1; i >= 0; i--) begin
         fb = v[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   // One full transaction: request, capture the serial command, optionally play
   // a card response, wait for ACK_OUT, then complete the handshake.
   // Times t are counted in cycles from the falling edge of cmd_oe_o.
   task automatic run_txn(input logic [39:0] c, input logic [15:0] s,
                          input logic [135:0] frame, input int nbits, input int idle,
                          output logic [47:0] sent, output int oe_cnt,
                          output logic idle_out, output int ack_t, output int st_t,
                          output logic [2:0] st, output logic [134:0] rsp,
                          output logic drop_ok);
      int t;
      int w;
      @(negedge clk);
      cmd = c; setting = s; req = 1'b1;
      sent = '0; oe_cnt = 0; ack_t = -1; st_t = -1; w = 0;
      @(negedge clk);
      // Inputs changed after the latch edge must have no effect.
      cmd = ~c; setting = ~s;
      while (!cmd_oe_o && w < 10) begin @(negedge clk); w++; end
      while (cmd_oe_o && oe_cnt < 100) begin
         sent = {sent[46:0], cmd_out_o};
         oe_cnt++;
         @(negedge clk);
      end
      idle_out = cmd_out_o;
      t = 0;
      if (nbits > 0) begin
         for (int i = 0; i < idle; i++) begin cmd_dat_i = 1'b1; @(negedge clk); t++; end
         for (int b = nbits - 1; b >= 0; b--) begin cmd_dat_i = frame[b]; @(negedge clk); t++; end
      end
      cmd_dat_i = 1'b1;
      while (!ack_out && t < 1000) begin
         @(negedge clk); t++;
         if (st_t < 0 && status != 3'b000) st_t = t;
      end
      if (ack_out) ack_t = t;
      st  = status;
      rsp = rsp_out;
      ack_in = 1'b1;
      @(negedge clk);
      drop_ok = !ack_out;
      ack_in = 1'b0; req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; req = 1'b0; ack_in = 1'b1; cmd_dat_i = 1'b0;
      cmd = 40'hFF_FFFF_FFFF; setting = 16'hFFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (cmd_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b want=0", cmd_oe_o); end
      checks++; if (cmd_out_o !== 1'b1) begin errors++; $display("FAIL reset_out got=%b want=1", cmd_out_o); end
      checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", ack_out); end
      checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status got=%b want=000", status); end
      checks++; if (rsp_out !== '0) begin errors++; $display("FAIL reset_rsp got=%h want=0", rsp_out); end
      rst = 1'b0; ack_in = 1'b0; cmd_dat_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_send_no_rsp;
      logic [47:0] sent; int oe_cnt, ack_t, st_t; logic idle_out, drop; logic [2:0] st; logic [134:0] rsp;
      run_txn(40'h40_0000_0000, 16'h0000, '0, 0, 0, sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (sent !== 48'h40_0000_0000_95) begin errors++; $display("FAIL cmd0_frame got=%h want=400000000095", sent); end
      checks++; if (oe_cnt !== 48) begin errors++; $display("FAIL cmd0_oe_cycles got=%0d want=48", oe_cnt); end
      checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL cmd0_idle_level got=%b want=1", idle_out); end
      checks++; if (ack_t !== 8) begin errors++; $display("FAIL cmd0_ack_delay got=%0d want=8", ack_t); end
      checks++; if (st !== 3'b000) begin errors++; $display("FAIL cmd0_status got=%b want=000", st); end
      checks++; if (drop !== 1'b1) begin errors++; $display("FAIL cmd0_ack_drop got=%b want=1", drop); end
   endtask

   task automatic test_rsp_short_ok;
      logic [47:0] sent; int oe_cnt, ack_t, st_t; logic idle_out, drop; logic [2:0] st; logic [134:0] rsp;
      run_txn(40'h48_0000_01AA, 16'h0005, 136'(48'h08_0000_01AA_13), 48, 5,
              sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (sent !== 48'h48_0000_01AA_87) begin errors++; $display("FAIL cmd8_frame got=%h want=48000001aa87", sent); end
      checks++; if (rsp !== 135'(47'h08_0000_01AA_13)) begin errors++; $display("FAIL r7_rsp got=%h want=08000001aa13", rsp); end
      checks++; if (st !== 3'b000) begin errors++; $display("FAIL r7_status got=%b want=000", st); end
      checks++; if (ack_t !== 61) begin errors++; $display("FAIL r7_ack_time got=%0d want=61", ack_t); end
   endtask

   task automatic test_rsp_crc;
      logic [47:0] sent; int oe_cnt, ack_t, st_t; logic idle_out, drop; logic [2:0] st; logic [134:0] rsp;
      run_txn(40'h48_0000_01AA, 16'h0005, 136'(48'h08_0000_01AA_15), 48, 5,
              sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (st !== 3'b010) begin errors++; $display("FAIL crc_err_status got=%b want=010", st); end
      checks++; if (rsp !== 135'(47'h08_0000_01AA_15)) begin errors++; $display("FAIL crc_err_rsp got=%h want=08000001aa15", rsp); end
      run_txn(40'h48_0000_01AA, 16'h0001, 136'(48'h08_0000_01AA_15), 48, 5,
              sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (st !== 3'b000) begin errors++; $display("FAIL crc_off_status got=%b want=000", st); end
   endtask

   task automatic test_timeout;
      logic [47:0] sent; int oe_cnt, ack_t, st_t; logic idle_out, drop; logic [2:0] st; logic [134:0] rsp;
      // rsp_en=1, ncc_dly=3, reserved bits set.
      run_txn(40'h77_0000_0000, 16'hFF19, '0, 0, 0, sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (sent !== 48'h77_0000_0000_65) begin errors++; $display("FAIL cmd55_frame got=%h want=770000000065", sent); end
      checks++; if (st_t !== 64) begin errors++; $display("FAIL timeout_time got=%0d want=64", st_t); end
      checks++; if (st !== 3'b001) begin errors++; $display("FAIL timeout_status got=%b want=001", st); end
      checks++; if (ack_t !== 75) begin errors++; $display("FAIL timeout_ack_time got=%0d want=75", ack_t); end
      checks++; if (rsp !== '0) begin errors++; $display("FAIL timeout_rsp got=%h want=0", rsp); end
   endtask

   task automatic test_long_end_err;
      logic [47:0] sent; int oe_cnt, ack_t, st_t; logic idle_out, drop; logic [2:0] st; logic [134:0] rsp;
      logic [119:0] pay;
      logic [135:0] fl;
      logic [6:0]   c;
      pay = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
      c   = ref_crc7(136'(pay), 120);
      fl  = {8'h3F, pay, c, 1'b0};
      run_txn(40'h42_0000_0000, 16'h0007, fl, 136, 2, sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (rsp !== fl[134:0]) begin errors++; $display("FAIL long_rsp got=%h want=%h", rsp, fl[134:0]); end
      checks++; if (st !== 3'b100) begin errors++; $display("FAIL long_status got=%b want=100", st); end
      checks++; if (ack_t !== 146) begin errors++; $display("FAIL long_ack_time got=%0d want=146", ack_t); end
   endtask

   task automatic test_reset_mid_send;
      logic [47:0] sent; int oe_cnt, ack_t, st_t; logic idle_out, drop; logic [2:0] st; logic [134:0] rsp;
      int w;
      logic spurious;
      @(negedge clk);
      cmd = 40'h40_0000_0000; setting = 16'h0000; req = 1'b1;
      @(negedge clk);
      w = 0;
      while (!cmd_oe_o && w < 10) begin @(negedge clk); w++; end
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (cmd_oe_o !== 1'b0) begin errors++; $display("FAIL rst_async_oe got=%b want=0", cmd_oe_o); end
      checks++; if (cmd_out_o !== 1'b1) begin errors++; $display("FAIL rst_async_out got=%b want=1", cmd_out_o); end
      checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL rst_async_ack got=%b want=0", ack_out); end
      @(negedge clk);
      req = 1'b0; rst = 1'b0;
      spurious = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (ack_out || cmd_oe_o) spurious = 1'b1;
      end
      checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL rst_no_ack got=%b want=0", spurious); end
      run_txn(40'h40_0000_0000, 16'h0000, '0, 0, 0, sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (sent !== 48'h40_0000_0000_95) begin errors++; $display("FAIL rst_next_frame got=%h want=400000000095", sent); end
      checks++; if (oe_cnt !== 48) begin errors++; $display("FAIL rst_next_oe got=%0d want=48", oe_cnt); end
      checks++; if (ack_t !== 8) begin errors++; $display("FAIL rst_next_ack got=%0d want=8", ack_t); end
   endtask

   task automatic test_back_to_back;
      logic [47:0] sent; int oe_cnt, ack_t, st_t; logic idle_out, drop; logic [2:0] st; logic [134:0] rsp;
      run_txn(40'h51_0000_0000, 16'h0000, '0, 0, 0, sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (sent !== 48'h51_0000_0000_55) begin errors++; $display("FAIL b2b_cmd17 got=%h want=510000000055", sent); end
      run_txn(40'h48_0000_01AA, 16'h0005, 136'(48'h08_0000_01AA_13), 48, 1,
              sent, oe_cnt, idle_out, ack_t, st_t, st, rsp, drop);
      checks++; if (rsp !== 135'(47'h08_0000_01AA_13)) begin errors++; $display("FAIL b2b_rsp got=%h want=08000001aa13", rsp); end
      checks++; if (st !== 3'b000) begin errors++; $display("FAIL b2b_status got=%b want=000", st); end
      checks++; if (ack_t !== 57) begin errors++; $display("FAIL b2b_ack_time got=%0d want=57", ack_t); end
   endtask

   initial begin
      test_reset();
      test_send_no_rsp();
      test_rsp_short_ok();
      test_rsp_crc();
      test_timeout();
      test_long_end_err();
      test_reset_mid_send();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sd_cmd_serial_host_p.md
SD_CMD_SERIAL_HOST_P -- requirements
Module: sd_cmd_serial_host_p

Interface
REQ-001 Parameter SHORT_LEN, default 48, short response frame length in bits (R1/R3/R6/R7).
REQ-002 Parameter LONG_LEN, default 136, long response frame length in bits (R2).
REQ-003 Parameter NCR_MAX, default 64, maximum command-to-response wait in SD_CLK_IN cycles.
REQ-004 Parameter NCC_W, default 4, width of the post-transaction delay count.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 SD_CLK_IN  in  1  card clock; all logic on rising edge.
REQ-007 RST_IN  in  1  asynchronous active-high reset.
REQ-008 SETTING_IN  in  16  [0] rsp_en, [1] rsp_long, [2] crc_chk, [3+NCC_W-1:3] ncc_dly, remaining bits reserved and ignored.
REQ-009 CMD_IN  in  40  start, dir, index[5:0], arg[31:0], MSB first.
REQ-010 REQ_IN  in  1  host request, 4-phase.
REQ-011 ACK_IN  in  1  host acknowledge of completion.
REQ-012 cmd_dat_i  in  1  CMD line input.
REQ-013 cmd_out_o  out  1  CMD line drive value.
REQ-014 cmd_oe_o  out  1  CMD line output enable.
REQ-015 ACK_OUT  out  1  transaction complete, result valid.
REQ-016 STATUS  out  3  [0] timeout, [1] crc_err, [2] end_err.
REQ-017 RSP_OUT  out  LONG_LEN-1  received frame without start bit, right-aligned.

Function
REQ-018 States: IDLE, SEND, NCR_WAIT, RECV, NCC_DLY, ACK, REQ_LOW.
REQ-019 IDLE, REQ_IN=1 at edge N: latch CMD_IN and SETTING_IN, clear STATUS and RSP_OUT, go to SEND.
REQ-020 SEND: 48 bits, one per cycle, cmd_oe_o=1 from edge N+1 through N+48; order: CMD_IN[39:0], CRC7 over those 40 bits, end bit 1.
REQ-021 CRC7 polynomial x^7+x^3+1, register initialised to 0 for each frame.
REQ-022 After SEND, cmd_oe_o=0 and cmd_out_o=1; rsp_en=0 goes to NCC_DLY, else NCR_WAIT.
REQ-023 NCR_WAIT: sample cmd_dat_i each cycle; first 0 is the start bit, go to RECV; NCR_MAX consecutive 1 samples sets STATUS[0] and goes to NCC_DLY.
REQ-024 RECV: shift in exactly SHORT_LEN-1 (rsp_long=0) or LONG_LEN-1 (rsp_long=1) further bits, MSB first, into RSP_OUT LSB end; short result occupies RSP_OUT[SHORT_LEN-2:0], upper bits 0.
REQ-025 Last received bit 0 sets STATUS[2].
REQ-026 crc_chk=1, short: CRC7 over start bit plus next 39 bits compared with bits [7:1]; long: CRC7 over the 120 bits after the 8-bit header compared with bits [7:1]; mismatch sets STATUS[1]; crc_chk=0 never sets STATUS[1].
REQ-027 NCC_DLY: wait 8+ncc_dly cycles with cmd_oe_o=0, then ACK.
REQ-028 ACK: ACK_OUT=1, STATUS and RSP_OUT stable; ACK_IN=1 goes to REQ_LOW with ACK_OUT=0 next cycle.
REQ-029 REQ_LOW: return to IDLE when REQ_IN=0; a new request needs REQ_IN low for at least one cycle.
REQ-030 REQ_IN or SETTING_IN changes after latch are ignored until IDLE.
REQ-031 ACK_IN outside ACK is ignored.
REQ-032 cmd_dat_i is ignored outside NCR_WAIT and RECV.
REQ-033 Counters saturate or stop at their terminal value, never wrap.

Reset
REQ-034 RST_IN=1 immediately, without a clock: state IDLE, cmd_oe_o=0, cmd_out_o=1, ACK_OUT=0, STATUS=0, RSP_OUT=0, counters 0, CRC 0.
REQ-035 Reset mid-SEND or mid-RECV abandons the transaction with no ACK_OUT; the first request after release behaves as a fresh one.

Verification
REQ-036 CMD_IN=40'h40_0000_0000, SETTING_IN=0 -> cmd_out_o serial 48'h40_0000_0000_95, cmd_oe_o high 48 cycles, ACK_OUT after 8 delay cycles, STATUS=0.
REQ-037 CMD_IN=40'h48_0000_01AA, rsp_en=1, crc_chk=1, card drives 48'h08_0000_01AA_13 after 5 idle cycles -> RSP_OUT=47'h08_0000_01AA_13 (start bit dropped), STATUS=0.
REQ-038 Same as REQ-037 with response byte 0x13 changed to 0x15 -> STATUS=3'b010; with crc_chk=0 -> STATUS=0.
REQ-039 rsp_en=1, cmd_dat_i held 1 -> STATUS=3'b001 exactly NCR_MAX cycles after cmd_oe_o falls, then ACK_OUT after 8+ncc_dly cycles.
REQ-040 rsp_long=1, 136-bit frame with valid CRC and end bit forced 0 -> 135 bits in RSP_OUT, STATUS=3'b100.
REQ-041 RST_IN pulsed at bit 20 of SEND -> cmd_oe_o low the same cycle, no ACK_OUT, next request emits a correct full frame.
